gate_controller: RTL and testbench

GATE_CONTROLLER -- requirements
Module: gate_controller

---
 rtl/gate_controller.sv | 96 +++++++++
 tb/tb_gate_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_controller.sv
// gate_controller: servo-driven parking gate with frame-synchronous PWM,
// open-hold timer, obstruction reversal and a sticky fail-safe fault.
module gate_controller #(
    parameter int PWM_PERIOD    = 1000,
    parameter int PULSE_CLOSED  = 50,
    parameter int STEP          = 5,
    parameter int MOVE_PERIODS  = 10,
    parameter int HOLD_PERIODS  = 20,
    parameter int MAX_REVERSALS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_open,
    input  logic       detected,
    output logic       servo_pwm,
    output logic [1:0] gate_state,
    output logic       gate_busy,
    output logic       car_passed,
    output logic       fault
);
    localparam int PULSE_MAX = PULSE_CLOSED + MOVE_PERIODS * STEP;
    localparam int CW = $clog2(PWM_PERIOD + PULSE_MAX + 1);
    localparam int PW = $clog2(MOVE_PERIODS + 1);
    localparam int HW = $clog2(HOLD_PERIODS + 1);
    localparam int RW = $clog2(MAX_REVERSALS + 1);
    typedef enum logic [1:0] {CLOSED = 2'd0, OPENING = 2'd1, OPEN = 2'd2, CLOSING = 2'd3} state_t;
    state_t        state, state_n;
    logic [CW-1:0] pwm_cnt, pulse_w;
    logic [PW-1:0] pos, pos_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [RW-1:0] rev_cnt, rev_n;
    logic          det_q, tick, hold_done;
    assign tick       = pwm_cnt == CW'(PWM_PERIOD - 1);
    assign hold_done  = hold_cnt == HW'(HOLD_PERIODS - 1);
    assign gate_state = state;
    assign gate_busy  = state == OPENING || state == CLOSING;
    // Detection has priority over a coincident step so a reversal never loses a position.
    always_comb begin
        state_n = state;
        pos_n   = pos;
        hold_n  = hold_cnt;
        rev_n   = rev_cnt;
        case (state)
            CLOSED: state_n = door_open && !fault ? OPENING : CLOSED;
            OPENING: if (tick) begin
                pos_n = pos == PW'(MOVE_PERIODS) ? pos : pos + 1'b1;
                if (pos_n == PW'(MOVE_PERIODS)) begin
                    state_n = OPEN;
                    hold_n  = '0;
                end
            end
            OPEN: if (door_open || detected) hold_n = '0;
            else if (tick) begin
                hold_n  = hold_done ? hold_cnt : hold_cnt + 1'b1;
                state_n = hold_done && !fault ? CLOSING : OPEN;
            end
            CLOSING: if (detected) begin
                state_n = OPENING;
                rev_n   = rev_cnt == RW'(MAX_REVERSALS) ? rev_cnt : rev_cnt + 1'b1;
            end else if (door_open) state_n = OPENING;
            else if (tick) begin
                pos_n = pos - 1'b1;
                if (pos_n == '0) begin
                    state_n = CLOSED;
                    rev_n   = '0;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CLOSED;
            pos        <= '0;
            pwm_cnt    <= '0;
            hold_cnt   <= '0;
            rev_cnt    <= '0;
            pulse_w    <= CW'(PULSE_CLOSED);
            servo_pwm  <= 1'b0;
            car_passed <= 1'b0;
            fault      <= 1'b0;
            det_q      <= 1'b0;
        end else begin
            pwm_cnt    <= tick ? '0 : pwm_cnt + 1'b1;
            if (pwm_cnt == '0) pulse_w <= CW'(PULSE_CLOSED) + CW'(pos) * CW'(STEP);
            servo_pwm  <= pwm_cnt < pulse_w;
            state      <= state_n;
            pos        <= pos_n;
            hold_cnt   <= hold_n;
            rev_cnt    <= rev_n;
            fault      <= fault || rev_n == RW'(MAX_REVERSALS);
            det_q      <= detected;
            car_passed <= det_q && !detected && state == OPEN;
        end
    end
endmodule

// File: tb/tb_gate_controller.sv
// tb_gate_controller: directed scenarios for gate_controller, checked every cycle
// against a frame-level behavioural model plus hand-computed literal expectations.
module tb_gate_controller;
    localparam int P  = 150;
    localparam int PC = 50;
    localparam int ST = 5;
    localparam int MV = 10;
    localparam int HP = 20;
    localparam int MR = 3;
    localparam int S_CLOSED = 0, S_OPENING = 1, S_OPEN = 2, S_CLOSING = 3;

    logic       clk = 1'b0;
    logic       reset, door_open, detected;
    logic       servo_pwm, gate_busy, car_passed, fault;
    logic [1:0] gate_state;

    int checks = 0, errors = 0, car_cnt = 0;
    int m_cnt, m_w, m_pos, m_state, m_hold, m_rev, m_fault, m_car, m_det;

    gate_controller #(
        .PWM_PERIOD(P), .PULSE_CLOSED(PC), .STEP(ST),
        .MOVE_PERIODS(MV), .HOLD_PERIODS(HP), .MAX_REVERSALS(MR)
    ) dut (
        .clk(clk), .reset(reset), .door_open(door_open), .detected(detected),
        .servo_pwm(servo_pwm), .gate_state(gate_state), .gate_busy(gate_busy),
        .car_passed(car_passed), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pack(int srv, int st, int car, int flt);
        return srv * 32 + st * 8 + ((st == S_OPENING || st == S_CLOSING) ? 4 : 0) + car * 2 + flt;
    endfunction

    function automatic int dut_vec();
        return int'({servo_pwm, gate_state, gate_busy, car_passed, fault});
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_w = PC; m_pos = 0; m_state = S_CLOSED;
        m_hold = 0; m_rev = 0; m_fault = 0; m_car = 0; m_det = 0;
    endtask

    // One clock of the gate as the requirements describe it, in frame terms.
    task automatic m_step(input int d_open, input int det);
        int tk, ns, np, nh, nr;
        tk = (m_cnt == P - 1);
        ns = m_state; np = m_pos; nh = m_hold; nr = m_rev;
        m_car = (m_det == 1 && det == 0 && m_state == S_OPEN) ? 1 : 0;
        m_det = det;
        if (m_cnt == 0) m_w = PC + m_pos * ST;
        if (m_state == S_CLOSED && d_open == 1 && m_fault == 0) ns = S_OPENING;
        if (m_state == S_OPENING && tk == 1) begin
            np = (m_pos < MV) ? m_pos + 1 : MV;
            if (np == MV) begin ns = S_OPEN; nh = 0; end
        end
        if (m_state == S_OPEN) begin
            if (d_open == 1 || det == 1) nh = 0;
            else if (tk == 1) begin
                if (m_hold == HP - 1 && m_fault == 0) ns = S_CLOSING;
                nh = (m_hold < HP - 1) ? m_hold + 1 : m_hold;
            end
        end
        if (m_state == S_CLOSING) begin
            if (det == 1) begin
                ns = S_OPENING;
                nr = (m_rev < MR) ? m_rev + 1 : MR;
                if (nr == MR) m_fault = 1;
            end else if (d_open == 1) ns = S_OPENING;
            else if (tk == 1) begin
                np = m_pos - 1;
                if (np == 0) begin ns = S_CLOSED; nr = 0; end
            end
        end
        m_state = ns; m_pos = np; m_hold = nh; m_rev = nr;
        m_cnt = (tk == 1) ? 0 : m_cnt + 1;
    endtask

    // Compare process: servo is high on frame cycles 1..width of the latched pulse.
    always begin
        @(posedge clk);
        if (!reset) m_reset();
        else m_step(int'(door_open), int'(detected));
        #1;
        chk("cycle outputs", dut_vec(), pack((m_cnt >= 1 && m_cnt <= m_w) ? 1 : 0, m_state, m_car, m_fault));
        if (car_passed) car_cnt++;
    end

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1);
    end

    task automatic wait_gate(input string name, input int s, input int exp_ticks);
        int t = 0, n = 0;
        while (int'(gate_state) != s && n < 40 * P) begin
            if (m_cnt == P - 1) t++;
            @(negedge clk);
            n++;
        end
        chk(name, int'(gate_state), s);
        if (exp_ticks >= 0) chk({name, " ticks"}, t, exp_ticks);
    endtask

    task automatic wait_ticks(input int k);
        repeat (k) begin
            while (m_cnt != P - 1) @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic measure(output int w);
        while (m_cnt != 0) @(negedge clk);
        w = 0;
        repeat (P) begin
            w += int'(servo_pwm);
            @(negedge clk);
        end
    endtask

    task automatic pulse_in(input bit is_det);
        if (is_det) detected = 1'b1; else door_open = 1'b1;
        @(negedge clk);
        detected = 1'b0;
        door_open = 1'b0;
    endtask

    initial begin
        int w, c0, bad;
        bit kinds [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int exp_f [4] = '{0, 0, 0, 1};
        reset = 1'b0; door_open = 1'b0; detected = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", dut_vec(), 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            measure(w);
            chk("idle width", w, 50);
            chk("idle state", int'(gate_state), 0);
        end
        c0 = car_cnt;
        detected = 1'b1;
        repeat (3) @(negedge clk);
        detected = 1'b0;
        repeat (3) @(negedge clk);
        chk("closed edge ignored", car_cnt - c0, 0);
        chk("closed stays", int'(gate_state), 0);
        // full open/hold/close cycle
        pulse_in(1'b0);
        chk("open request", int'(gate_state), 1);
        chk("busy opening", int'(gate_busy), 1);
        wait_gate("to open", S_OPEN, 10);
        wait_gate("to closing", S_CLOSING, 20);
        wait_gate("to closed", S_CLOSED, 10);
        measure(w);
        chk("closed width", w, 50);
        // pass-through
        c0 = car_cnt;
        pulse_in(1'b0);
        wait_gate("pass open", S_OPEN, 10);
        measure(w);
        chk("open width", w, 100);
        detected = 1'b1;
        repeat (3 * P) @(negedge clk);
        detected = 1'b0;
        chk("no early car", car_cnt - c0, 0);
        wait_gate("hold restart", S_CLOSING, 20);
        chk("car passed once", car_cnt - c0, 1);
        wait_gate("pass closed", S_CLOSED, 10);
        // obstruction at pos 6, coinciding with a frame tick
        pulse_in(1'b0);
        wait_gate("obs open", S_OPEN, 10);
        wait_gate("obs closing", S_CLOSING, 20);
        wait_ticks(4);
        while (m_cnt != P - 1) @(negedge clk);
        pulse_in(1'b1);
        chk("reversal state", int'(gate_state), 1);
        for (int i = 0; i < 5; i++) begin
            measure(w);
            chk("reopen width", w, 80 + 5 * i);
        end
        chk("reopened", int'(gate_state), 2);
        wait_gate("obs reclose", S_CLOSING, -1);
        wait_gate("obs closed", S_CLOSED, -1);
        // async reset mid-OPENING at pos 4
        pulse_in(1'b0);
        wait_ticks(4);
        repeat (20) @(negedge clk);
        chk("pre-reset servo", int'(servo_pwm), 1);
        reset = 1'b0;
        #1;
        chk("async reset outputs", dut_vec(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        measure(w);
        chk("post-reset width", w, 50);
        chk("post-reset state", int'(gate_state), 0);
        // reversals: detect, door, detect, detect -> fault on the third detection
        pulse_in(1'b0);
        wait_gate("fault open", S_OPEN, 10);
        for (int i = 0; i < 4; i++) begin
            wait_gate("fault closing", S_CLOSING, 20);
            wait_ticks(1);
            repeat (5) @(negedge clk);
            pulse_in(kinds[i]);
            chk("fault reversal", int'(gate_state), 1);
            chk("fault flag", int'(fault), exp_f[i]);
            wait_gate("fault reopen", S_OPEN, 1);
        end
        bad = 0;
        repeat (50 * P) begin
            if (gate_state != 2'd2) bad++;
            @(negedge clk);
        end
        chk("fail-safe open", bad, 0);
        chk("fault sticky", int'(fault), 1);
        measure(w);
        chk("fail-safe width", w, 100);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
